// File: rtl/key_input_ctrl.sv
// key_input_ctrl: memory-mapped push-button peripheral.
// Synchronises and debounces N_KEYS raw keys, latches press events as sticky
// write-1-to-clear bits and raises a maskable level interrupt.
// Register map (word index): 0 STATE (debounced level, read-only),
// 1 EVENT (press events, W1C), 2 MASK (interrupt enables), 3 reserved.
module key_input_ctrl #(
  parameter int N_KEYS          = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_raw,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_STATE = 2'd0;
  localparam logic [1:0] ADDR_EVENT = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;

  logic [N_KEYS-1:0] pressed;
  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] stable_q;
  logic [N_KEYS-1:0] stable_d;
  logic [N_KEYS-1:0] key_rise;
  logic [N_KEYS-1:0] event_q;
  logic [N_KEYS-1:0] event_d;
  logic [N_KEYS-1:0] mask_q;
  logic [N_KEYS-1:0] mask_d;
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_d [N_KEYS];

  // Internally a key is always 1 when pressed, whatever the pin polarity.
  assign pressed = ACTIVE_LOW ? ~key_raw : key_raw;

  // Upper write-data bits have no register behind them when N_KEYS < 32.
  if (N_KEYS < 32) begin : g_unused_wdata
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[31:N_KEYS];
  end

  // Two-flop synchroniser; reset puts both stages in the released state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pressed;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive samples that disagree with the accepted level;
  // any agreeing sample restarts the count, the last count accepts the change.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_KEYS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Event and mask next state; a press accepted in the same cycle as a W1C
  // write to its bit must not be lost, so the set is applied last.
  always_comb begin
    key_rise = stable_d & ~stable_q;
    event_d  = event_q;
    mask_d   = mask_q;
    if (we && (addr == ADDR_EVENT)) begin
      event_d = event_q & ~wdata[N_KEYS-1:0];
    end
    if (we && (addr == ADDR_MASK)) begin
      mask_d = wdata[N_KEYS-1:0];
    end
    event_d = event_d | key_rise;
  end

  // Debounce state, sticky events and interrupt mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= '0;
      event_q  <= '0;
      mask_q   <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      event_q  <= event_d;
      mask_q   <= mask_d;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Combinational read mux, registers zero-extended to the bus width.
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_STATE: rdata[N_KEYS-1:0] = stable_q;
      ADDR_EVENT: rdata[N_KEYS-1:0] = event_q;
      ADDR_MASK:  rdata[N_KEYS-1:0] = mask_q;
      default:    rdata = '0;
    endcase
  end

  // Level interrupt straight from the registers, no added delay.
  assign irq = |(event_q & mask_q);

endmodule

// File: tb/tb_key_input_ctrl.sv
// Scoreboard bench for key_input_ctrl (N_KEYS=8, DEBOUNCE_CYCLES=16, ACTIVE_LOW=1).
// The driver pushes the expected read data / irq for every cycle it drives;
// a monitor on the falling edge pops and compares.
module tb_key_input_ctrl;

  localparam int NK = 8;
  localparam int DB = 16;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic [7:0]  key_raw = 8'hFF;
  logic [1:0]  addr    = 2'd0;
  logic        we      = 1'b0;
  logic [31:0] wdata   = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  key_input_ctrl #(
    .N_KEYS(NK),
    .DEBOUNCE_CYCLES(DB),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_raw(key_raw),
    .addr(addr),
    .we(we),
    .wdata(wdata),
    .rdata(rdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Scoreboard queues
  logic [31:0] exp_rd_q [$];
  logic        exp_irq_q[$];
  string       tag_q    [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model: a key's level flips once the last DB synchronised samples
  // all disagree with it; samples are the pressed pins two clocks earlier.
  logic [NK-1:0] m_stable = '0;
  logic [NK-1:0] m_event  = '0;
  logic [NK-1:0] m_mask   = '0;
  logic [NK-1:0] pin_q[$] = '{8'h00, 8'h00};
  logic [NK-1:0] win_q[$];

  always @(posedge clk) begin : ref_model
    logic [NK-1:0] pn, smp, all1, all0, nxt, rise;
    pn = ~key_raw;
    if (reset) begin
      pin_q.delete();
      pin_q.push_back('0);
      pin_q.push_back('0);
      win_q.delete();
      m_stable = '0;
      m_event  = '0;
      m_mask   = '0;
    end else begin
      smp = pin_q.pop_front();
      pin_q.push_back(pn);
      win_q.push_back(smp);
      if (win_q.size() > DB) void'(win_q.pop_front());
      all1 = '1;
      all0 = '1;
      foreach (win_q[k]) begin
        all1 &= win_q[k];
        all0 &= ~win_q[k];
      end
      nxt = m_stable;
      if (win_q.size() == DB) nxt = (m_stable & ~all0) | (~m_stable & all1);
      rise = nxt & ~m_stable;
      if (we && addr == 2'd1) m_event = (m_event & ~wdata[NK-1:0]) | rise;
      else                    m_event = m_event | rise;
      if (we && addr == 2'd2) m_mask = wdata[NK-1:0];
      m_stable = nxt;
    end
  end

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, m_stable};
      2'd1:    return {24'h0, m_event};
      2'd2:    return {24'h0, m_mask};
      default: return 32'h0;
    endcase
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (exp_rd_q.size() != 0) begin
      logic [31:0] er;
      logic        ei;
      string       t;
      er = exp_rd_q.pop_front();
      ei = exp_irq_q.pop_front();
      t  = tag_q.pop_front();
      n_cmp++;
      if (rdata !== er || irq !== ei) begin
        n_bad++;
        $display("FAIL %s: got rdata=%08h irq=%b, want rdata=%08h irq=%b", t, rdata, irq, er, ei);
      end
    end
  end

  task automatic chk(input logic [31:0] got, input logic [31:0] want, input string t);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %08h, want %08h", t, got, want);
    end
  endtask

  task automatic drive(input logic [7:0] k, input logic [1:0] a, input logic w,
                       input logic [31:0] wd, input logic r);
    @(posedge clk);
    #1;
    key_raw = k;
    addr    = a;
    we      = w;
    wdata   = wd;
    reset   = r;
  endtask

  // Expectation from the reference model
  task automatic step(input logic [7:0] k, input logic [1:0] a, input logic w,
                      input logic [31:0] wd, input logic r, input string t);
    drive(k, a, w, wd, r);
    exp_rd_q.push_back(model_read(a));
    exp_irq_q.push_back(|(m_event & m_mask));
    tag_q.push_back(t);
  endtask

  // Hand-derived expectation
  task automatic stepc(input logic [7:0] k, input logic [1:0] a, input logic w,
                       input logic [31:0] wd, input logic r, input string t,
                       input logic [31:0] er, input logic ei);
    drive(k, a, w, wd, r);
    exp_rd_q.push_back(er);
    exp_irq_q.push_back(ei);
    tag_q.push_back(t);
  endtask

  int         plen[5] = '{1, 3, 7, 12, 15};
  logic [7:0] kk;
  logic [7:0] cur;
  logic [1:0] aa;
  int         rst_left;
  int         wait_n;

  initial begin
    // 1: reset, all keys released, everything reads zero
    for (int j = 0; j < 3; j++) stepc(8'hFF, j[1:0], 1'b0, 32'd0, 1'b1, "t1_rst", 32'd0, 1'b0);
    for (int j = 0; j < 100; j++) stepc(8'hFF, j[1:0], 1'b0, 32'd0, 1'b0, "t1_idle", 32'd0, 1'b0);
    @(negedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      addr = j[1:0];
      #1;
      chk(rdata, 32'd0, "t1_reset_state");
    end
    chk({31'd0, irq}, 32'd0, "t1_reset_irq");
    addr = 2'd3;

    // 2: key 0 pressed for 40 cycles, STATE rises 18 cycles after the pin
    for (int j = 0; j < 40; j++)
      stepc(8'hFE, 2'd0, 1'b0, 32'd0, 1'b0, "t2_state", (j >= 18) ? 32'h1 : 32'h0, 1'b0);
    stepc(8'hFE, 2'd1, 1'b0, 32'd0, 1'b0, "t2_event", 32'h1, 1'b0);
    stepc(8'hFE, 2'd2, 1'b0, 32'd0, 1'b0, "t2_mask", 32'h0, 1'b0);
    stepc(8'hFE, 2'd3, 1'b0, 32'd0, 1'b0, "t2_rsvd", 32'h0, 1'b0);
    for (int j = 0; j < 25; j++) step(8'hFF, j[1:0], 1'b0, 32'd0, 1'b0, "t2_release");
    stepc(8'hFF, 2'd1, 1'b1, 32'hFFFF_FFFF, 1'b0, "t2_clr", 32'h1, 1'b0);
    stepc(8'hFF, 2'd1, 1'b0, 32'd0, 1'b0, "t2_clr_rd", 32'h0, 1'b0);

    // 3: short glitches on key 0 (up to 15 cycles) never change anything
    for (int p = 0; p < 5; p++)
      for (int j = 0; j < 200; j++) begin
        kk = (j < plen[p]) ? 8'hFE : 8'hFF;
        aa = j[0] ? 2'd1 : 2'd0;
        stepc(kk, aa, 1'b0, 32'd0, 1'b0, "t3_glitch", 32'h0, 1'b0);
      end

    // 4: key 3 bounces 3 low / 2 high, then stays low from cycle 5
    for (int j = 0; j < 41; j++) begin
      kk = (j == 3 || j == 4) ? 8'hFF : 8'hF7;
      stepc(kk, 2'd0, 1'b0, 32'd0, 1'b0, "t4_bounce", (j >= 23) ? 32'h8 : 32'h0, 1'b0);
    end
    stepc(8'hF7, 2'd1, 1'b0, 32'd0, 1'b0, "t4_event", 32'h8, 1'b0);

    // 5: unmask pending event, W1C, then clear racing a fresh press
    stepc(8'hF7, 2'd2, 1'b1, 32'h9, 1'b0, "t5_mask_wr", 32'h0, 1'b0);
    stepc(8'hF7, 2'd1, 1'b0, 32'd0, 1'b0, "t5_irq", 32'h8, 1'b1);
    stepc(8'hF7, 2'd1, 1'b1, 32'h8, 1'b0, "t5_clr", 32'h8, 1'b1);
    stepc(8'hF7, 2'd1, 1'b0, 32'd0, 1'b0, "t5_clr_rd", 32'h0, 1'b0);
    stepc(8'hF7, 2'd2, 1'b0, 32'd0, 1'b0, "t5_mask_rd", 32'h9, 1'b0);
    for (int j = 0; j < 30; j++) step(8'hFF, j[1:0], 1'b0, 32'd0, 1'b0, "t5_release");
    for (int j = 0; j < 17; j++) step(8'hF7, 2'd0, 1'b0, 32'd0, 1'b0, "t5_press");
    stepc(8'hF7, 2'd1, 1'b1, 32'h8, 1'b0, "t5_race_wr", 32'h0, 1'b0);
    stepc(8'hF7, 2'd1, 1'b0, 32'd0, 1'b0, "t5_race_set", 32'h8, 1'b1);
    stepc(8'hF7, 2'd0, 1'b0, 32'd0, 1'b0, "t5_race_state", 32'h8, 1'b1);
    stepc(8'hF7, 2'd1, 1'b1, 32'h8, 1'b0, "t5_clr2", 32'h8, 1'b1);
    stepc(8'hF7, 2'd1, 1'b0, 32'd0, 1'b0, "t5_clr2_rd", 32'h0, 1'b0);

    // 6: key 5 held through a 3-cycle reset, re-qualified 18 cycles later
    for (int j = 0; j < 30; j++) step(8'hDF, j[1:0], 1'b0, 32'd0, 1'b0, "t6_hold");
    step(8'hDF, 2'd0, 1'b0, 32'd0, 1'b1, "t6_rst0");
    stepc(8'hDF, 2'd0, 1'b0, 32'd0, 1'b1, "t6_rst1", 32'h0, 1'b0);
    stepc(8'hDF, 2'd1, 1'b0, 32'd0, 1'b1, "t6_rst2", 32'h0, 1'b0);
    for (int j = 0; j < 26; j++) begin
      aa = j[0] ? 2'd1 : 2'd0;
      stepc(8'hDF, aa, 1'b0, 32'd0, 1'b0, "t6_requal", (j >= 18) ? 32'h20 : 32'h0, 1'b0);
    end

    // Randomised traffic: key toggles, bus reads/writes, occasional reset
    cur = 8'hDF;
    rst_left = 0;
    for (int n = 0; n < 3000; n++) begin
      logic r;
      logic w;
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 24) == 0) cur[i] = ~cur[i];
      if (rst_left > 0) begin
        rst_left--;
        r = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        rst_left = $urandom_range(0, 2);
        r = 1'b1;
      end else begin
        r = 1'b0;
      end
      aa = 2'($urandom_range(0, 3));
      w  = ($urandom_range(0, 7) == 0);
      step(cur, aa, w, $urandom(), r, "rand");
    end

    wait_n = 0;
    while (exp_rd_q.size() != 0 && wait_n < 10) begin
      @(negedge clk);
      #1;
      wait_n++;
    end
    if (exp_rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: wait expired with %0d expectations pending", exp_rd_q.size());
    end
    if (n_cmp == 0) begin
      n_bad++;
      $display("FAIL: no comparisons performed");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
